// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter for eight requesters sharing an 8:1 mux; drives the
// registered one-hot grant and the mux selects {s0,s1,s2} of the granted index.
module mux8_rr_arbiter #(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic       s0,
    output logic       s1,
    output logic       s2,
    output logic       busy
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

    logic [0:0]       state;
    logic [2:0]       ptr;
    logic [2:0]       sel;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       gnt_q;

    // Returns {found, index}; searches ptr+1 .. ptr+8 (mod 8), so ptr is last.
    function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'b0;
        for (int i = 1; i <= 8; i++) begin
            idx = p + 3'(i);
            if (!res[3] && r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    logic       hold_req;
    logic       expired;
    logic [3:0] pick;
    logic       do_grant;
    logic       go_idle;

    always_comb begin
        hold_req = |(req & gnt_q);
        expired  = (cnt == HOLD_MAX);
        pick     = 4'b0;
        do_grant = 1'b0;
        go_idle  = 1'b0;
        if (state == IDLE) begin
            pick     = rr_pick(req, ptr);
            do_grant = pick[3];
        end else if (!hold_req) begin
            // Holder released: it is excluded from the re-arbitration.
            pick     = rr_pick(req & ~gnt_q, ptr);
            do_grant = pick[3];
            go_idle  = !pick[3];
        end else if (expired) begin
            pick     = rr_pick(req, ptr);
            do_grant = pick[3];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= 3'd7;
            sel   <= 3'd0;
            cnt   <= '0;
            gnt_q <= 8'h00;
        end else if (do_grant) begin
            state <= GRANT;
            ptr   <= pick[2:0];
            sel   <= pick[2:0];
            cnt   <= CNT_W'(1);
            gnt_q <= 8'h01 << pick[2:0];
        end else if (go_idle) begin
            // Selects keep the last index so the mux output stays stable.
            state <= IDLE;
            cnt   <= '0;
            gnt_q <= 8'h00;
        end else if (state == GRANT) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign gnt  = gnt_q;
    assign s0   = sel[2];
    assign s1   = sel[1];
    assign s2   = sel[0];
    assign busy = |gnt_q;

endmodule

// File: doc/mux8_rr_arbiter.md
Name: mux8_rr_arbiter

Overview:
- Round-robin arbiter and select controller for the shared 8:1 single-bit mux datapath.
- Eight requesters compete for the mux output.
- The block grants one requester at a time and drives the mux selects {s0,s1,s2} (s0 = MSB) to the granted index.
- A hold counter bounds each grant, so a continuously requesting source cannot starve the others.

Parameters:
- MAX_HOLD, 4: maximum consecutive cycles one grant lasts while others wait. Legal range 1..255.
- CNT_W, 8: width of the hold counter. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- req  input  8  request vector; req[k] asks for mux input ik.
- gnt  output  8  one-hot grant, registered; all zero when idle.
- s0  output  1  mux select MSB (index bit 2), registered.
- s1  output  1  mux select bit 1, registered.
- s2  output  1  mux select LSB (index bit 0), registered.
- busy  output  1  high while any grant is active.

Behaviour:
- Reset (rst_n=0 at a clock edge), regardless of state:
  - gnt=0, s0=s1=s2=0, busy=0.
  - Hold counter = 0.
  - Last-grant pointer = 7, so the first search starts at index 0.
  - State = IDLE.
  - Reset mid-grant drops the grant on that edge. No grant is issued in the reset cycle.
- Arbitration function: search indices ptr+1, ptr+2, … wrapping modulo 8, ending at ptr itself. The first k with req[k]=1 wins. The current holder therefore has the lowest priority.
- IDLE:
  - If req==0: stay in IDLE.
  - Otherwise, in the next cycle: gnt=onehot(winner), {s0,s1,s2}=winner, busy=1, counter=1, ptr=winner, go to GRANT.
  - Latency: req sampled high at edge N gives gnt visible after edge N.
- GRANT, holder h, evaluated each edge in priority order:
  - Release: req[h]=0. Rearbitrate over the remaining requests, excluding h.
    - If a winner w exists: grant w with no idle bubble (gnt, selects and ptr updated, counter=1).
    - If none: gnt=0, busy=0, go to IDLE.
  - Expiry: req[h]=1 and counter==MAX_HOLD. Rearbitrate with ptr=h.
    - If another requester exists, it wins.
    - If h is the only requester, h is re-granted.
    - In both cases counter=1.
  - Otherwise: counter increments and the grant is unchanged.
- Selects in IDLE: s0..s2 keep the last granted index, so the mux output stays stable. After reset they are 000.
- Select encoding: {s0,s1,s2}=3'b000 selects i0 and 3'b111 selects i7. The selects always equal the index of the set bit in gnt whenever busy=1.
- Invariants:
  - gnt is always zero or one-hot.
  - busy == |gnt.
  - The counter never exceeds MAX_HOLD.
- Simultaneous events:
  - A requester that raises req in the same cycle the holder releases is eligible in that arbitration.
  - Changes to req on non-holder bits never affect the current grant before release or expiry.
- MAX_HOLD=1: rotation happens every cycle among the active requesters.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with req=8'hFF -> gnt=0, busy=0, selects=000. Release reset -> next cycle gnt=8'h01, selects=000.
- Single requester: req=8'h20 held for 10 cycles, MAX_HOLD=4 -> gnt=8'h20 continuously, selects=101, counter cycles 1..4. No gap in gnt at expiry.
- Rotation: req=8'h91 (bits 0,4,7) held, MAX_HOLD=4, start from reset -> grant order 0,4,7,0, each for 4 cycles. The selects track 000,100,111,000.
- Early release with handoff: holder 2 (req=8'h0C) drops req[2] after 2 cycles -> the next edge grants 3 (gnt=8'h08, selects=011) with no idle cycle. Then req=0 -> gnt=0, busy=0, selects stay 011.
- Wrap-around: ptr=6, req=8'h41 (bits 0 and 6) -> index 0 wins before 6.
- Reset mid-grant: assert rst_n=0 while gnt=8'h10 -> gnt=0 at that edge. After release, with req=8'h10 -> gnt=8'h10 one cycle later.
